// File: rtl/core_pkg.sv
// Shared types and encodings for the RV32I core pipeline: MEM/WB FSM states,
// writeback-source selects and load funct3 codes.
package core_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } mws_state_e;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Sub-word load alignment and sign/zero extension. Instantiated by mem_wb_stage
// only when MEM_WB_LOAD_EXT_EN is defined.
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    ext = rdata;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with variable-latency load wait, timeout watchdog
// and optional sub-word load extension (enable with MEM_WB_LOAD_EXT_EN).
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemReadM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] PC_PlusM,
  input  logic [4:0]      RdM,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            StallM,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PC_PlusW,
  output logic [4:0]      RdW,
  output logic            mem_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mws_state_e      state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            capture;
  logic            timeout_hit;
  logic [XLEN-1:0] load_data;

`ifdef MEM_WB_LOAD_EXT_EN
  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (mem_rdata),
    .addr   (ALUResultM[1:0]),
    .funct3 (Funct3M),
    .ext    (load_data)
  );
`else
  logic unused_funct3;
  assign unused_funct3 = ^Funct3M;
  assign load_data     = mem_rdata;
`endif

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    StallM      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (ValidM && MemReadM && !mem_rvalid) begin
          StallM    = 1'b1;
          count_nxt = CW'(1);
          state_nxt = WAIT_MEM;
        end else begin
          capture = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          capture   = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (count == CW'(TIMEOUT_CYCLES)) begin
          // Forced completion: the load retires with zero data and an error flag.
          capture     = 1'b1;
          timeout_hit = 1'b1;
          count_nxt   = '0;
          state_nxt   = IDLE;
        end else begin
          StallM    = 1'b1;
          count_nxt = count + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PC_PlusW   <= '0;
      RdW        <= '0;
      mem_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      mem_err <= timeout_hit;
      if (capture) begin
        ValidW     <= ValidM;
        RegWriteW  <= ValidM && RegWriteM && (RdM != 5'd0);
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= timeout_hit ? '0 : load_data;
        PC_PlusW   <= PC_PlusM;
        RdW        <= RdM;
      end else begin
        // Stalled on an outstanding load: present a bubble to writeback.
        ValidW    <= 1'b0;
        RegWriteW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven single-cycle vectors plus
// directed sequences for multi-cycle load, timeout and reset corners.
module tb_mem_wb_stage;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk;
  logic            rst_n;
  logic            ValidM, RegWriteM, MemReadM, mem_rvalid;
  logic [1:0]      ResultSrcM;
  logic [2:0]      Funct3M;
  logic [XLEN-1:0] ALUResultM, PC_PlusM, mem_rdata;
  logic [4:0]      RdM;
  logic            StallM, ValidW, RegWriteW, mem_err;
  logic [1:0]      ResultSrcW;
  logic [XLEN-1:0] ALUResultW, ReadDataW, PC_PlusW;
  logic [4:0]      RdW;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemReadM   (MemReadM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .PC_PlusM   (PC_PlusM),
    .RdM        (RdM),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .StallM     (StallM),
    .ValidW     (ValidW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PC_PlusW   (PC_PlusW),
    .RdW        (RdW),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, rw, mr, rv;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu, pc4, rdata;
    logic [4:0]  rd;
    logic        exp_valid, exp_rw, chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vec[12];
  int   n_vec;

  function automatic vec_t mk(string nm, logic v, logic rw, logic mr, logic rv,
                              logic [1:0] src, logic [2:0] f3, logic [31:0] alu,
                              logic [31:0] pc4, logic [31:0] rdata, logic [4:0] rd,
                              logic ev, logic erw, logic cd, logic [31:0] ed);
    vec_t t;
    t.name = nm; t.valid = v; t.rw = rw; t.mr = mr; t.rv = rv; t.src = src; t.f3 = f3;
    t.alu = alu; t.pc4 = pc4; t.rdata = rdata; t.rd = rd;
    t.exp_valid = ev; t.exp_rw = erw; t.chk_data = cd; t.exp_data = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic rv,
                       input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] rdata, input logic [4:0] rd);
    ValidM = v; RegWriteM = rw; MemReadM = mr; mem_rvalid = rv; ResultSrcM = src;
    Funct3M = f3; ALUResultM = alu; PC_PlusM = pc4; mem_rdata = rdata; RdM = rd;
  endtask

  initial begin
    int  stall_cycles;
    logic done;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();

    // Reset state
    check("rst_validw", ValidW, 0);
    check("rst_regwritew", RegWriteW, 0);
    check("rst_aluw", ALUResultW, 0);
    check("rst_readdata", ReadDataW, 0);
    check("rst_pcw", PC_PlusW, 0);
    check("rst_rdw", RdW, 0);
    check("rst_srcw", ResultSrcW, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_stall", StallM, 0);
    rst_n = 1'b1;

    n_vec = 0;
    vec[n_vec++] = mk("alu_op", 1, 1, 0, 0, 2'b00, 3'b000, 32'h0000_1234, 32'h0000_0104,
                      32'h0, 5'd5, 1, 1, 0, 32'h0);
    vec[n_vec++] = mk("load_zero_lat", 1, 1, 1, 1, 2'b01, 3'b010, 32'h0000_1000, 32'h0000_0108,
                      32'hDEAD_BEEF, 5'd7, 1, 1, 1, 32'hDEAD_BEEF);
    vec[n_vec++] = mk("bubble", 0, 1, 0, 0, 2'b00, 3'b000, 32'h0000_0777, 32'h0000_010C,
                      32'h0, 5'd3, 0, 0, 0, 32'h0);
    vec[n_vec++] = mk("rd_x0", 1, 1, 0, 0, 2'b00, 3'b000, 32'h0000_0042, 32'h0000_0110,
                      32'h0, 5'd0, 1, 0, 0, 32'h0);
    vec[n_vec++] = mk("src_11", 1, 1, 0, 0, 2'b11, 3'b000, 32'hA5A5_0000, 32'h0000_0114,
                      32'h0, 5'd31, 1, 1, 0, 32'h0);
    vec[n_vec++] = mk("pc4_no_write", 1, 0, 0, 0, 2'b10, 3'b000, 32'h0000_0003, 32'h0000_0118,
                      32'h0, 5'd1, 1, 0, 0, 32'h0);
    vec[n_vec++] = mk("rvalid_no_load", 1, 1, 0, 1, 2'b00, 3'b000, 32'h0000_0055, 32'h0000_011C,
                      32'h1111_2222, 5'd8, 1, 1, 0, 32'h0);
    vec[n_vec++] = mk("invalid_load", 0, 1, 1, 0, 2'b01, 3'b010, 32'h0000_2000, 32'h0000_0120,
                      32'h0, 5'd9, 0, 0, 0, 32'h0);
`ifdef MEM_WB_LOAD_EXT_EN
    vec[n_vec++] = mk("ext_lb_a0", 1, 1, 1, 1, 2'b01, 3'b000, 32'h0000_3000, 32'h0000_0124,
                      32'h80F0_7F80, 5'd10, 1, 1, 1, 32'hFFFF_FF80);
    vec[n_vec++] = mk("ext_lbu_a3", 1, 1, 1, 1, 2'b01, 3'b100, 32'h0000_3003, 32'h0000_0128,
                      32'h80F0_7F80, 5'd11, 1, 1, 1, 32'h0000_0080);
    vec[n_vec++] = mk("ext_lh_a2", 1, 1, 1, 1, 2'b01, 3'b001, 32'h0000_3002, 32'h0000_012C,
                      32'h80F0_7F80, 5'd12, 1, 1, 1, 32'hFFFF_80F0);
`endif

    for (int i = 0; i < n_vec; i++) begin
      drive(vec[i].valid, vec[i].rw, vec[i].mr, vec[i].rv, vec[i].src, vec[i].f3,
            vec[i].alu, vec[i].pc4, vec[i].rdata, vec[i].rd);
      #1;
      check({vec[i].name, "_stall"}, StallM, 0);
      tick();
      check({vec[i].name, "_validw"}, ValidW, vec[i].exp_valid);
      check({vec[i].name, "_regwritew"}, RegWriteW, vec[i].exp_rw);
      if (vec[i].exp_valid) begin
        check({vec[i].name, "_aluw"}, ALUResultW, vec[i].alu);
        check({vec[i].name, "_pcw"}, PC_PlusW, vec[i].pc4);
        check({vec[i].name, "_rdw"}, RdW, vec[i].rd);
        check({vec[i].name, "_srcw"}, ResultSrcW, vec[i].src);
      end
      if (vec[i].chk_data) check({vec[i].name, "_readdata"}, ReadDataW, vec[i].exp_data);
      check({vec[i].name, "_mem_err"}, mem_err, 0);
    end

    // Load answered three cycles late
    drive(1, 1, 1, 0, 2'b01, 3'b010, 32'h0000_2000, 32'h0000_0200, 32'h0, 5'd9);
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (StallM) stall_cycles++;
      tick();
      check($sformatf("late_bubble_valid_%0d", i), ValidW, 0);
      check($sformatf("late_bubble_rw_%0d", i), RegWriteW, 0);
    end
    check("late_stall_cycles", stall_cycles, 3);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    #1;
    check("late_release_stall", StallM, 0);
    tick();
    mem_rvalid = 1'b0;
    check("late_validw", ValidW, 1);
    check("late_regwritew", RegWriteW, 1);
    check("late_readdata", ReadDataW, 32'hCAFE_F00D);
    check("late_rdw", RdW, 9);
    check("late_mem_err", mem_err, 0);

    // Timeout with no response at all
    drive(1, 1, 1, 0, 2'b01, 3'b010, 32'h0000_2004, 32'h0000_0204, 32'h1234_5678, 5'd14);
    stall_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 3 * TO && !done; i++) begin
      #1;
      if (StallM) stall_cycles++;
      else done = 1'b1;
      tick();
    end
    check("to_completed", done, 1);
    check("to_stall_cycles", stall_cycles, TO);
    check("to_mem_err", mem_err, 1);
    check("to_readdata_zero", ReadDataW, 0);
    check("to_validw", ValidW, 1);
    check("to_rdw", RdW, 14);
    // Late response after the timeout is ignored
    drive(1, 1, 0, 1, 2'b00, 3'b000, 32'h0000_0099, 32'h0000_0208, 32'hFFFF_FFFF, 5'd15);
    #1;
    check("to_late_resp_stall", StallM, 0);
    tick();
    check("to_mem_err_pulse", mem_err, 0);
    check("to_after_validw", ValidW, 1);
    check("to_after_aluw", ALUResultW, 32'h0000_0099);

    // Reset while waiting on a load
    drive(1, 1, 1, 0, 2'b01, 3'b010, 32'h0000_2008, 32'h0000_020C, 32'h0, 5'd16);
    tick();
    tick();
    #1;
    check("rstw_stalled", StallM, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstw_validw", ValidW, 0);
    check("rstw_aluw", ALUResultW, 0);
    check("rstw_rdw", RdW, 0);
    check("rstw_pcw", PC_PlusW, 0);
    check("rstw_mem_err", mem_err, 0);
    drive(1, 1, 0, 0, 2'b00, 3'b000, 32'h0000_0077, 32'h0000_0210, 32'h0, 5'd0);
    #1;
    check("rstw_idle_stall", StallM, 0);
    tick();
    check("rstw_x0_validw", ValidW, 1);
    check("rstw_x0_regwritew", RegWriteW, 0);
    check("rstw_x0_aluw", ALUResultW, 32'h0000_0077);
    for (int i = 0; i < TO + 2; i++) begin
      tick();
      check($sformatf("rstw_no_err_%0d", i), mem_err, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
